// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared constants and types for the pipeline flush controller.
// Contents: pipe register count, stage indices, flush counter width, refill FSM states.
package pipe_flush_ctrl_pkg;

    // Number of pipeline registers covered by the flush/stall masks
    localparam int unsigned NUM_PIPE_MASKS = 5;

    // Stage indices; instructions move from the higher index to the lower one
    localparam int unsigned PIPE_PC     = 4;
    localparam int unsigned PIPE_IF_ID  = 3;
    localparam int unsigned PIPE_ID_EX  = 2;
    localparam int unsigned PIPE_EX_MEM = 1;
    localparam int unsigned PIPE_MEM_WB = 0;

    // Width of the saturating flush event counter
    localparam int unsigned FLUSH_CNT_W = 16;

    typedef enum logic [0:0] {
        REFILL_IDLE   = 1'b0,
        REFILL_ACTIVE = 1'b1
    } refill_state_e;

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Flush-mask interface between the branch unit (master) and the flush controller (slave).
// master drives: flush, stall, fetch_valid
// slave drives : stage_enable, stage_bubble (combinational), stage_valid, redirect,
//                refilling, flush_count (registered)
interface pipe_flush_ctrl_if #(
    parameter int unsigned NUM_STAGES = pipe_flush_ctrl_pkg::NUM_PIPE_MASKS,
    parameter int unsigned CNT_W      = pipe_flush_ctrl_pkg::FLUSH_CNT_W
);
    logic [NUM_STAGES-1:0] flush;
    logic [NUM_STAGES-1:0] stall;
    logic                  fetch_valid;
    logic [NUM_STAGES-1:0] stage_enable;
    logic [NUM_STAGES-1:0] stage_bubble;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  redirect;
    logic                  refilling;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output flush, stall, fetch_valid,
        input  stage_enable, stage_bubble, stage_valid, redirect, refilling, flush_count
    );

    modport slave (
        input  flush, stall, fetch_valid,
        output stage_enable, stage_bubble, stage_valid, redirect, refilling, flush_count
    );
endinterface

// File: rtl/pipe_valid_cell.sv
// Valid bit of one pipeline register with its load-enable and load-NOP strobes.
// Ports: clk, reset (async, active-high); flush/hold for this register;
//        bubble_src = NOP-insert condition from the upstream side; valid_in = upstream valid;
//        enable_c/bubble_c combinational strobes; valid registered.
module pipe_valid_cell (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic hold,
    input  logic bubble_src,
    input  logic valid_in,
    output logic enable_c,
    output logic bubble_c,
    output logic valid
);
    logic valid_d;

    // Flush overrides a hold so the killed register still loads its NOP
    assign enable_c = ~hold | flush;
    assign bubble_c = flush | bubble_src;

    // Priority: flush kills, hold keeps, bubble empties, else take upstream
    always_comb begin
        valid_d = valid_in;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hold) begin
            valid_d = valid;
        end else if (bubble_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else begin
            valid <= valid_d;
        end
    end
endmodule

// File: rtl/pipe_flush_ctrl.sv
// Consumer of the branch unit's flush masks: applies flush/stall to the pipeline
// registers, tracks per-register valid bits, the post-redirect refill window and
// a saturating count of flush cycles.
// Ports: clk, reset (async, active-high), bus (pipe_flush_ctrl_if.slave).
module pipe_flush_ctrl
    import pipe_flush_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_PIPE_MASKS,
    parameter int unsigned CNT_W      = FLUSH_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    pipe_flush_ctrl_if.slave   bus
);
    localparam int unsigned RCNT_W = $clog2(NUM_STAGES);

    logic [NUM_STAGES-1:0] hold_c;
    logic [NUM_STAGES-1:0] bubble_src_c;
    logic [NUM_STAGES-1:0] valid_up_c;
    logic [NUM_STAGES-1:0] enable_c;
    logic [NUM_STAGES-1:0] bubble_c;
    logic [NUM_STAGES-1:0] valid_q;
    logic                  any_flush_c;

    refill_state_e         state_q, state_d;
    logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
    logic                  redirect_q;
    logic [CNT_W-1:0]      count_q;

    assign any_flush_c = |bus.flush;

    // A stall holds its own register and everything upstream of it
    always_comb begin
        logic acc;
        acc    = 1'b0;
        hold_c = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            acc       = acc | bus.stall[k];
            hold_c[k] = acc;
        end
    end

    // Register k gets a NOP when it advances but its source is held; the top takes from fetch
    assign bubble_src_c = {~bus.fetch_valid, ~hold_c[NUM_STAGES-2:0] & hold_c[NUM_STAGES-1:1]};
    assign valid_up_c   = {bus.fetch_valid, valid_q[NUM_STAGES-1:1]};

    for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_cell
        pipe_valid_cell u_cell (
            .clk        (clk),
            .reset      (reset),
            .flush      (bus.flush[k]),
            .hold       (hold_c[k]),
            .bubble_src (bubble_src_c[k]),
            .valid_in   (valid_up_c[k]),
            .enable_c   (enable_c[k]),
            .bubble_c   (bubble_c[k]),
            .valid      (valid_q[k])
        );
    end

    // Refill window: any flush (re)starts it; it drains one step per advance of the last register
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (any_flush_c) begin
            state_d = REFILL_ACTIVE;
            rcnt_d  = RCNT_W'(NUM_STAGES - 1);
        end else if (state_q == REFILL_ACTIVE && enable_c[PIPE_MEM_WB]) begin
            if (rcnt_q == RCNT_W'(1)) begin
                state_d = REFILL_IDLE;
            end else begin
                rcnt_d = rcnt_q - RCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REFILL_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Redirect strobe and saturating flush counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_q <= 1'b0;
            count_q    <= '0;
        end else begin
            redirect_q <= any_flush_c;
            if (any_flush_c && count_q != {CNT_W{1'b1}}) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.stage_enable = enable_c;
    assign bus.stage_bubble = bubble_c;
    assign bus.stage_valid  = valid_q;
    assign bus.redirect     = redirect_q;
    assign bus.refilling    = (state_q == REFILL_ACTIVE);
    assign bus.flush_count  = count_q;
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Self-checking bench for pipe_flush_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the pipeline.
module tb_pipe_flush_ctrl;
    import pipe_flush_ctrl_pkg::*;

    localparam int unsigned NS = NUM_PIPE_MASKS;
    localparam int unsigned CW = FLUSH_CNT_W;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_flush_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    pipe_flush_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passes = 0;
    int total  = 0;

    // Reference model state
    logic [NS-1:0] m_valid;
    logic          m_redirect;
    int            m_refill_left;
    int            m_count;

    // Comb strobes captured mid-cycle by the last step
    logic [NS-1:0] obs_en;
    logic [NS-1:0] obs_bub;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid       = '0;
        m_redirect    = 1'b0;
        m_refill_left = 0;
        m_count       = 0;
    endtask

    // One clock cycle: drive inputs, check strobes, clock, then check registered state
    task automatic step(input logic [NS-1:0] f, input logic [NS-1:0] s, input logic fv,
                        input bit check);
        logic [NS-1:0] held, en, bub, nxt;
        logic          upstream;
        bus.flush       = f;
        bus.stall       = s;
        bus.fetch_valid = fv;
        #1;
        // A register is frozen if any stall exists at it or further down the pipe
        for (int k = 0; k < int'(NS); k++) begin
            held[k] = 1'b0;
            for (int j = 0; j <= k; j++) if (s[j]) held[k] = 1'b1;
        end
        for (int k = 0; k < int'(NS); k++) begin
            en[k] = f[k] || !held[k];
            if (k == int'(NS) - 1) begin
                bub[k]   = f[k] || !fv;
                upstream = fv;
            end else begin
                bub[k]   = f[k] || (!held[k] && held[k+1]);
                upstream = m_valid[k+1];
            end
            if (f[k])        nxt[k] = 1'b0;
            else if (held[k]) nxt[k] = m_valid[k];
            else if (bub[k])  nxt[k] = 1'b0;
            else              nxt[k] = upstream;
        end
        obs_en  = bus.stage_enable;
        obs_bub = bus.stage_bubble;
        if (check) begin
            chk("stage_enable", 32'(obs_en), 32'(en));
            chk("stage_bubble", 32'(obs_bub), 32'(bub));
        end
        @(posedge clk);
        #1;
        m_valid    = nxt;
        m_redirect = (f != '0);
        if (f != '0)                      m_refill_left = int'(NS) - 1;
        else if (m_refill_left > 0 && en[0]) m_refill_left--;
        if (f != '0 && m_count < CNT_MAX) m_count++;
        if (check) begin
            chk("stage_valid", 32'(bus.stage_valid), 32'(m_valid));
            chk("redirect",    32'(bus.redirect),    32'(m_redirect));
            chk("refilling",   32'(bus.refilling),   32'(m_refill_left > 0));
            chk("flush_count", 32'(bus.flush_count), 32'(m_count));
        end
    endtask

    initial begin
        logic [NS-1:0] fill_exp [5];
        int            hi;
        fill_exp[0] = 5'b10000;
        fill_exp[1] = 5'b11000;
        fill_exp[2] = 5'b11100;
        fill_exp[3] = 5'b11110;
        fill_exp[4] = 5'b11111;

        // Reset state
        reset           = 1'b1;
        bus.flush       = '0;
        bus.stall       = '0;
        bus.fetch_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid",     32'(bus.stage_valid), 32'h0);
        chk("rst_redirect",  32'(bus.redirect),    32'h0);
        chk("rst_refilling", 32'(bus.refilling),   32'h0);
        chk("rst_count",     32'(bus.flush_count), 32'h0);
        reset = 1'b0;

        // Fill from empty
        for (int i = 0; i < 5; i++) begin
            step('0, '0, 1'b1, 1'b1);
            chk("fill_valid",     32'(bus.stage_valid), 32'(fill_exp[i]));
            chk("fill_refilling", 32'(bus.refilling),   32'h0);
        end

        // Branch flush of everything behind PC
        step(5'b01111, '0, 1'b1, 1'b1);
        chk("br_valid",    32'(bus.stage_valid), 32'h10);
        chk("br_redirect", 32'(bus.redirect),    32'h1);
        chk("br_count",    32'(bus.flush_count), 32'h1);
        hi = bus.refilling ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step('0, '0, 1'b1, 1'b1);
            if (i == 0) chk("br_redirect_drop", 32'(bus.redirect), 32'h0);
            if (bus.refilling) hi++;
        end
        chk("br_refill_len", 32'(hi), 32'd4);

        // Stall at ID/EX
        chk("st_pre_valid", 32'(bus.stage_valid), 32'h1f);
        step('0, 5'b00100, 1'b1, 1'b1);
        chk("st_enable", 32'(obs_en),          32'h03);
        chk("st_bubble", 32'(obs_bub),         32'h02);
        chk("st_valid",  32'(bus.stage_valid), 32'h1d);

        // Flush and stall on the same register
        step('0, '0, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b1);
        chk("fs_pre_valid", 32'(bus.stage_valid), 32'h1f);
        step(5'b00100, 5'b00100, 1'b1, 1'b1);
        chk("fs_enable",   32'(obs_en),                32'h07);
        chk("fs_bubble2",  32'(obs_bub[2]),            32'h1);
        chk("fs_held",     32'(bus.stage_valid[4:3]),  32'h3);
        chk("fs_cleared",  32'(bus.stage_valid[2]),    32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [NS-1:0] f, s;
            f = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
            s = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            step(f, s, 1'($urandom), 1'b1);
        end

        // Counter saturation
        for (int i = 0; i < 65540; i++) begin
            step(NS'($urandom_range(1, 31)), NS'($urandom), 1'($urandom), 1'b0);
        end
        chk("sat_count", 32'(bus.flush_count), 32'hffff);
        step(5'b00001, '0, 1'b1, 1'b1);
        chk("sat_nowrap", 32'(bus.flush_count), 32'hffff);

        // Reset mid-operation with full pipe and refill window open
        for (int i = 0; i < 6; i++) step('0, '0, 1'b1, 1'b1);
        step(5'b00001, '0, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b1);
        chk("mid_valid",     32'(bus.stage_valid), 32'h1f);
        chk("mid_refilling", 32'(bus.refilling),   32'h1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_valid",     32'(bus.stage_valid), 32'h0);
        chk("arst_redirect",  32'(bus.redirect),    32'h0);
        chk("arst_refilling", 32'(bus.refilling),   32'h0);
        chk("arst_count",     32'(bus.flush_count), 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
